// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - MEM-stage load/store initiator for a byte-enabled word memory
module load_store_unit #(
  parameter int ADDR_WIDTH = 32,
  parameter int MEM_WORDS  = 64,
  parameter int DATA_WIDTH = 32,
  localparam int IDX_W     = $clog2(MEM_WORDS)
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic                  i_req_we,
  input  logic [2:0]            i_req_funct3,
  input  logic [ADDR_WIDTH-1:0] i_req_addr,
  input  logic [DATA_WIDTH-1:0] i_req_wdata,
  output logic                  o_resp_valid,
  output logic [DATA_WIDTH-1:0] o_resp_rdata,
  output logic                  o_resp_err,
  output logic                  o_mem_en,
  output logic                  o_mem_we,
  output logic [3:0]            o_mem_be,
  output logic [IDX_W-1:0]      o_mem_addr,
  output logic [DATA_WIDTH-1:0] o_mem_wdata,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_BEAT0 = 3'd1,
    S_BEAT1 = 3'd2,
    S_DONE  = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  state_t                  r_state;
  logic                    r_we;
  logic [2:0]              r_funct3;
  logic [1:0]              r_off;
  logic                    r_cross;
  logic [3:0]              r_be_hi;
  logic [DATA_WIDTH-1:0]   r_wd_hi;
  logic [DATA_WIDTH-1:0]   r_lo;

  logic                    r_req_ready;
  logic                    r_resp_valid;
  logic                    r_resp_err;
  logic                    r_mem_en;
  logic                    r_mem_we;
  logic [3:0]              r_mem_be;
  logic [IDX_W-1:0]        r_mem_addr;
  logic [DATA_WIDTH-1:0]   r_mem_wdata;

  logic [3:0]              w_mask;
  logic [7:0]              w_be8;
  logic [2*DATA_WIDTH-1:0] w_wd64;
  logic                    w_illegal;
  logic                    w_accept;
  logic [DATA_WIDTH-1:0]   w_lo;
  logic [DATA_WIDTH-1:0]   w_hi;
  logic [DATA_WIDTH-1:0]   w_shifted;
  logic [DATA_WIDTH-1:0]   w_ext;
  logic                    w_sign;
  logic                    w_unused_addr;

  // Only the byte offset and word index of the address matter; the rest is ignored.
  assign w_unused_addr = ^i_req_addr;

  // Request geometry: size mask shifted to the byte offset spans up to two words.
  always_comb begin
    w_mask = 4'b0001;
    case (i_req_funct3[1:0])
      2'b00:   w_mask = 4'b0001;
      2'b01:   w_mask = 4'b0011;
      default: w_mask = 4'b1111;
    endcase
    w_be8     = {4'b0000, w_mask} << i_req_addr[1:0];
    w_wd64    = {{DATA_WIDTH{1'b0}}, i_req_wdata} << {i_req_addr[1:0], 3'b000};
    w_illegal = (i_req_funct3 == 3'b011) || (i_req_funct3 == 3'b110) ||
                (i_req_funct3 == 3'b111) || (i_req_we && i_req_funct3[2]);
    w_accept  = i_req_valid && r_req_ready;
  end

  // Load result: the final beat's read data arrives in DONE, so it is aligned and extended here.
  always_comb begin
    w_lo      = r_cross ? r_lo : i_mem_rdata;
    w_hi      = r_cross ? i_mem_rdata : {DATA_WIDTH{1'b0}};
    w_shifted = DATA_WIDTH'({w_hi, w_lo} >> {r_off, 3'b000});
    w_sign    = ~r_funct3[2];
    w_ext     = w_shifted;
    case (r_funct3[1:0])
      2'b00:   w_ext = {{24{w_sign & w_shifted[7]}}, w_shifted[7:0]};
      2'b01:   w_ext = {{16{w_sign & w_shifted[15]}}, w_shifted[15:0]};
      default: w_ext = w_shifted;
    endcase
    o_resp_rdata = ((r_state == S_DONE) && !r_we) ? w_ext : {DATA_WIDTH{1'b0}};
  end

  // Control FSM; every handshake and memory-port output is a register updated here.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state      <= S_IDLE;
      r_we         <= 1'b0;
      r_funct3     <= 3'b000;
      r_off        <= 2'b00;
      r_cross      <= 1'b0;
      r_be_hi      <= 4'b0000;
      r_wd_hi      <= '0;
      r_lo         <= '0;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_mem_en     <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_be     <= 4'b0000;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_we        <= i_req_we;
            r_funct3    <= i_req_funct3;
            r_off       <= i_req_addr[1:0];
            r_cross     <= |w_be8[7:4];
            r_be_hi     <= w_be8[7:4];
            r_wd_hi     <= i_req_we ? w_wd64[2*DATA_WIDTH-1:DATA_WIDTH] : '0;
            r_mem_addr  <= i_req_addr[2 +: IDX_W];
            r_req_ready <= 1'b0;
            if (w_illegal) begin
              r_state      <= S_ERR;
              r_resp_valid <= 1'b1;
              r_resp_err   <= 1'b1;
            end else begin
              r_state     <= S_BEAT0;
              r_mem_en    <= 1'b1;
              r_mem_we    <= i_req_we;
              r_mem_be    <= w_be8[3:0];
              r_mem_wdata <= i_req_we ? w_wd64[DATA_WIDTH-1:0] : '0;
            end
          end
        end
        S_BEAT0: begin
          if (r_cross) begin
            r_state     <= S_BEAT1;
            r_mem_addr  <= r_mem_addr + 1'b1;
            r_mem_be    <= r_be_hi;
            r_mem_wdata <= r_wd_hi;
          end else begin
            r_state      <= S_DONE;
            r_mem_en     <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_be     <= 4'b0000;
            r_resp_valid <= 1'b1;
          end
        end
        S_BEAT1: begin
          r_lo         <= i_mem_rdata;
          r_state      <= S_DONE;
          r_mem_en     <= 1'b0;
          r_mem_we     <= 1'b0;
          r_mem_be     <= 4'b0000;
          r_resp_valid <= 1'b1;
        end
        S_DONE: begin
          r_state      <= S_IDLE;
          r_resp_valid <= 1'b0;
          r_req_ready  <= 1'b1;
        end
        S_ERR: begin
          r_state      <= S_IDLE;
          r_resp_valid <= 1'b0;
          r_resp_err   <= 1'b0;
          r_req_ready  <= 1'b1;
        end
        default: begin
          r_state      <= S_IDLE;
          r_resp_valid <= 1'b0;
          r_resp_err   <= 1'b0;
          r_mem_en     <= 1'b0;
          r_mem_we     <= 1'b0;
          r_mem_be     <= 4'b0000;
          r_req_ready  <= 1'b1;
        end
      endcase
    end
  end

  assign o_req_ready  = r_req_ready;
  assign o_resp_valid = r_resp_valid;
  assign o_resp_err   = r_resp_err;
  assign o_mem_en     = r_mem_en;
  assign o_mem_we     = r_mem_we;
  assign o_mem_be     = r_mem_be;
  assign o_mem_addr   = r_mem_addr;
  assign o_mem_wdata  = r_mem_wdata;

endmodule
